// File: rtl/wb_regfile.sv
// wb_regfile: RV32 architectural register file with write-through bypass,
// registered debug read port and saturating retired-write counter.
module wb_regfile #(
  parameter int              NREG    = 32,
  parameter int              DW      = 32,
  parameter int              SP_IDX  = 2,
  parameter logic [DW-1:0]   SP_INIT = 32'h0000_0FFC,
  parameter int              CNT_W   = 16,
  localparam int             AW      = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             RFWr,
  input  logic             wb_hold,
  input  logic [AW-1:0]    A3,
  input  logic [DW-1:0]    WD,
  input  logic [AW-1:0]    A1,
  input  logic [AW-1:0]    A2,
  output logic [DW-1:0]    RD1,
  output logic [DW-1:0]    RD2,
  input  logic [AW-1:0]    dbg_sel,
  output logic [DW-1:0]    dbg_data,
  output logic [CNT_W-1:0] wr_count
);

  logic [DW-1:0]    r_regs [NREG];
  logic [DW-1:0]    r_dbg;
  logic [CNT_W-1:0] r_cnt;
  logic             w_we;

  // A write commits only out of reset, unstalled, and never to x0.
  // Gating by rstn also kills the bypass while reset is held.
  assign w_we = rstn & RFWr & ~wb_hold & (A3 != '0);

  // Register array: reset image, then WB commits.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= (i == SP_IDX) ? SP_INIT : '0;
      end
    end else if (w_we) begin
      r_regs[A3] <= WD;
    end
  end

  // Operand reads with write-through bypass; x0 reads as zero.
  always_comb begin
    RD1 = '0;
    RD2 = '0;
    if (A1 != '0) begin
      RD1 = (w_we && (A1 == A3)) ? WD : r_regs[A1];
    end
    if (A2 != '0) begin
      RD2 = (w_we && (A2 == A3)) ? WD : r_regs[A2];
    end
  end

  // Debug port samples the stored (pre-write) value.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_dbg <= '0;
    end else begin
      r_dbg <= (dbg_sel == '0) ? '0 : r_regs[dbg_sel];
    end
  end

  // Retired-write counter, saturating at all-ones.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (w_we && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign dbg_data = r_dbg;
  assign wr_count = r_cnt;

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed table plus randomized checks of wb_regfile
// against an array-based reference model.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rstn;
  logic        RFWr, wb_hold;
  logic [4:0]  A3, A1, A2, dbg_sel;
  logic [31:0] WD;
  logic [31:0] RD1, RD2, dbg_data;
  logic [31:0] RD1_4, RD2_4, dbg_data_4;
  logic [15:0] wr_count;
  logic [3:0]  wr_count_4;

  always #5 clk = ~clk;

  wb_regfile u_dut (
    .clk(clk), .rstn(rstn), .RFWr(RFWr), .wb_hold(wb_hold),
    .A3(A3), .WD(WD), .A1(A1), .A2(A2),
    .RD1(RD1), .RD2(RD2),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data),
    .wr_count(wr_count)
  );

  wb_regfile #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rstn(rstn), .RFWr(RFWr), .wb_hold(wb_hold),
    .A3(A3), .WD(WD), .A1(A1), .A2(A2),
    .RD1(RD1_4), .RD2(RD2_4),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data_4),
    .wr_count(wr_count_4)
  );

  typedef struct {
    logic        rfwr;
    logic        hold;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [4:0]  dsel;
    logic [31:0] e_rd1;
    logic [31:0] e_rd2;
    logic [31:0] e_dbg;
    int          e_cnt;
  } vec_t;

  vec_t        tbl [7];
  logic [31:0] m_reg [32];
  int          m_cnt, m_cnt4;
  int          n_vec, n_err;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
    m_reg[2] = 32'h0000_0FFC;
    m_cnt = 0;
    m_cnt4 = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    bit we;
    we = RFWr && !wb_hold && (A3 != 0);
    if (a == 0) return 0;
    if (we && a == A3) return WD;
    return m_reg[a];
  endfunction

  // One cycle: drive, check reads before the edge, commit, check registered.
  task automatic apply(input logic rf, input logic hd, input logic [4:0] a3,
                       input logic [31:0] wd, input logic [4:0] a1,
                       input logic [4:0] a2, input logic [4:0] ds);
    logic [31:0] e_dbg;
    bit we;
    @(negedge clk);
    RFWr = rf; wb_hold = hd; A3 = a3; WD = wd;
    A1 = a1; A2 = a2; dbg_sel = ds;
    #1;
    chk("rd1", RD1, m_read(a1));
    chk("rd2", RD2, m_read(a2));
    chk("rd1_w4", RD1_4, m_read(a1));
    e_dbg = (ds == 0) ? 32'h0 : m_reg[ds];
    we = rf && !hd && (a3 != 0);
    @(posedge clk);
    if (we) begin
      m_reg[a3] = wd;
      m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
      m_cnt4 = (m_cnt4 < 15) ? m_cnt4 + 1 : 15;
    end
    #1;
    chk("dbg", dbg_data, e_dbg);
    chk("cnt", 32'(wr_count), 32'(m_cnt));
    chk("cnt4", 32'(wr_count_4), 32'(m_cnt4));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    RFWr = 0; wb_hold = 0; A3 = 0; WD = 0;
    A1 = 0; A2 = 0; dbg_sel = 0;
    #3;
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rstn = 1'b0;
    RFWr = 0; wb_hold = 0; A3 = 0; WD = 0;
    A1 = 5'd2; A2 = 5'd5; dbg_sel = 0;
    model_reset();

    tbl[0] = '{1, 0, 5'd5, 32'hDEAD_BEEF, 5'd2, 5'd0, 5'd2,
               32'h0000_0FFC, 32'h0, 32'h0000_0FFC, 1};
    tbl[1] = '{0, 0, 5'd0, 32'h0, 5'd5, 5'd5, 5'd5,
               32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1};
    tbl[2] = '{1, 1, 5'd7, 32'h1234_5678, 5'd7, 5'd7, 5'd7,
               32'h0, 32'h0, 32'h0, 1};
    tbl[3] = '{0, 0, 5'd7, 32'h1234_5678, 5'd7, 5'd5, 5'd7,
               32'h0, 32'hDEAD_BEEF, 32'h0, 1};
    tbl[4] = '{1, 0, 5'd7, 32'h1234_5678, 5'd7, 5'd7, 5'd7,
               32'h1234_5678, 32'h1234_5678, 32'h0, 2};
    tbl[5] = '{1, 0, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd7, 5'd0,
               32'h0, 32'h1234_5678, 32'h0, 2};
    tbl[6] = '{0, 0, 5'd0, 32'h0, 5'd0, 5'd7, 5'd7,
               32'h0, 32'h1234_5678, 32'h1234_5678, 2};

    // Reset state while rstn is held low.
    #12;
    chk("rst_rd1", RD1, 32'h0000_0FFC);
    chk("rst_rd2", RD2, 32'h0);
    chk("rst_cnt", 32'(wr_count), 32'h0);
    chk("rst_dbg", dbg_data, 32'h0);
    @(negedge clk);
    rstn = 1'b1;

    // Directed table: constant expectations plus model cross-check.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      RFWr = tbl[i].rfwr; wb_hold = tbl[i].hold; A3 = tbl[i].a3;
      WD = tbl[i].wd; A1 = tbl[i].a1; A2 = tbl[i].a2;
      dbg_sel = tbl[i].dsel;
      #1;
      chk($sformatf("t%0d_rd1", i), RD1, tbl[i].e_rd1);
      chk($sformatf("t%0d_rd2", i), RD2, tbl[i].e_rd2);
      @(posedge clk);
      #1;
      chk($sformatf("t%0d_dbg", i), dbg_data, tbl[i].e_dbg);
      chk($sformatf("t%0d_cnt", i), 32'(wr_count), 32'(tbl[i].e_cnt));
    end
    // Bring the model in line with the table's effects.
    m_reg[5] = 32'hDEAD_BEEF;
    m_reg[7] = 32'h1234_5678;
    m_cnt = 2;
    m_cnt4 = 2;

    // Randomized traffic with frequent index collisions.
    for (int i = 0; i < 400; i++) begin
      logic [4:0] a3, a1, a2;
      a3 = 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 3) == 0) ? a3 : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? a3 : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 15) == 0) a1 = 0;
      apply(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0),
            a3, $urandom, a1, a2, 5'($urandom_range(0, 31)));
    end

    // Counter saturation: 20 writes to x1 on a fresh reset.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      apply(1, 0, 5'd1, 32'(i), 5'd1, 5'd0, 5'd1);
    end
    chk("sat_cnt4", 32'(wr_count_4), 32'hF);
    chk("sat_cnt16", 32'(wr_count), 32'd20);

    // Async reset landing on a pending write.
    @(negedge clk);
    RFWr = 1; wb_hold = 0; A3 = 5'd3; WD = 32'hA5A5_A5A5;
    A1 = 5'd3; A2 = 5'd2; dbg_sel = 5'd1;
    #1;
    chk("mr_byp", RD1, 32'hA5A5_A5A5);
    #1;
    rstn = 1'b0;
    #1;
    chk("mr_rd1", RD1, 32'h0);
    chk("mr_rd2", RD2, 32'h0000_0FFC);
    chk("mr_cnt", 32'(wr_count), 32'h0);
    chk("mr_cnt4", 32'(wr_count_4), 32'h0);
    chk("mr_dbg", dbg_data, 32'h0);
    @(posedge clk);
    #1;
    model_reset();
    @(negedge clk);
    RFWr = 0;
    rstn = 1'b1;
    apply(0, 0, 5'd0, 32'h0, 5'd3, 5'd1, 5'd3);
    chk("mr_reg3", RD1, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Architectural integer register file for the pipelined RV32 core: 32 x 32-bit registers.
- Consumer end of the write-back data path. Takes the selected write-back word (WD), the destination index and the write enable from the WB stage.
- Serves two operand reads to the ID stage.
- Provides write-through bypass so that an ID-stage read in the same cycle as a WB write returns the new value. Also provides a debug read port and a retired-write counter.

Parameters:
- NREG, 32, number of registers; index width is log2(NREG) = 5.
- DW, 32, data width.
- SP_IDX, 2, register loaded with SP_INIT at reset.
- SP_INIT, 32'h0000_0FFC, reset value of register SP_IDX.
- CNT_W, 16, width of the retired-write counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rstn  input  1  asynchronous, active-low reset.
- RFWr  input  1  write enable from WB stage.
- wb_hold  input  1  WB stage stalled; suppresses the write this cycle.
- A3  input  5  destination register index.
- WD  input  32  write-back data.
- A1  input  5  read port 1 index.
- A2  input  5  read port 2 index.
- RD1  output  32  read port 1 data.
- RD2  output  32  read port 2 data.
- dbg_sel  input  5  debug read index.
- dbg_data  output  32  debug read data (registered).
- wr_count  output  CNT_W  number of committed writes to non-zero registers (saturating).

Behaviour:
- Reset:
  - rstn low clears all registers to 0 immediately, except reg[SP_IDX] = SP_INIT.
  - dbg_data = 0; wr_count = 0.
  - RD1/RD2 are combinational and therefore reflect the reset contents (0, or SP_INIT for index SP_IDX).
- Reset release is synchronous to the first clk edge after rstn rises; no write occurs on that edge unless RFWr is high.
- Commit condition: we = RFWr & ~wb_hold & (A3 != 0). On the rising edge with we=1, reg[A3] <= WD.
- x0: reg[0] is never written; a read of index 0 always returns 0, including under bypass.
- Reads are combinational, zero latency:
  - RD1 = (A1 == 0) ? 0 : (we && A1 == A3) ? WD : reg[A1].
  - RD2 is identical, using A2.
- Bypass applies only when we=1. If wb_hold=1 or RFWr=0, the stored value is returned.
- A1 == A2 == A3 with we=1: both ports return WD.
- Debug port, one-cycle latency:
  - dbg_data <= (dbg_sel == 0) ? 0 : reg[dbg_sel] on each edge.
  - Reads the pre-write value when dbg_sel == A3 on a write edge (no bypass on debug).
- wr_count:
  - Increments by 1 on each edge where we=1.
  - Saturates at all-ones and does not wrap.
  - Writes to x0 and held writes do not count.
- Reset mid-operation: rstn asserted in the same cycle as a write discards that write; registers and counter take their reset values.
- No X propagation: every output is defined from reset onward.
- Width rules: indices are unsigned 5-bit; WD is stored unmodified, with no sign or zero extension here.

Test Plan:
- Reset: rstn=0 -> after release, RD1(A1=2) = 32'h0000_0FFC, RD2(A2=5) = 0, wr_count = 0, dbg_data = 0.
- Basic write/read: RFWr=1, A3=5, WD=32'hDEAD_BEEF, one edge; then A1=5 -> RD1 = 32'hDEAD_BEEF, wr_count = 1; dbg_sel=5 -> dbg_data = 32'hDEAD_BEEF one cycle later.
- Bypass: same cycle RFWr=1, A3=7, WD=32'h1234_5678, A1=7, A2=7 -> RD1 = RD2 = 32'h1234_5678 before the edge. Repeat with wb_hold=1 -> RD1 = old reg[7] (0), and reg[7] is unchanged after the edge.
- x0: RFWr=1, A3=0, WD=32'hFFFF_FFFF, A1=0 -> RD1 = 0 before and after the edge; wr_count unchanged.
- Counter saturation: CNT_W=4, 20 consecutive writes to A3=1 -> wr_count = 4'hF, no wrap.
- Async reset mid-write: RFWr=1, A3=3, WD=32'hA5A5_A5A5, drop rstn before the edge -> reg[3] = 0, wr_count = 0, RD1(A1=3) = 0 immediately.
